// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : One elastic pipeline stage: a valid bit plus a data word,
//               with the accept/advance handshake that lets bubbles collapse
//               so a full chain still moves one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_down_accept,
    output logic             o_accept,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_advance;

    // The held word leaves when the next stage (or the consumer) takes it.
    assign w_advance = r_valid & i_down_accept;
    // A stage can load when it is empty or emptying this cycle.
    assign o_accept  = ~r_valid | w_advance;

    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Reset clears everything; flush only drops the valid bit and keeps data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (o_accept) begin
            r_valid <= i_up_valid;
            r_data  <= i_up_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_register.sv
`default_nettype none
// ============================================================================
// Module      : pipe_register
// Description : Parameterised valid/ready register pipeline of STAGES elastic
//               stages with flush and a registered occupancy counter. The only
//               combinational path is the ready chain out_ready -> in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_register #(
    parameter  int WIDTH  = 16,
    parameter  int STAGES = 2,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    // w_accept[i] is stage i's accept; the extra top bit is the consumer.
    logic [STAGES:0]   w_accept;
    logic [STAGES-1:0] w_valid;
    logic [WIDTH-1:0]  w_data [STAGES];
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [CW-1:0]     r_count;

    assign w_accept[STAGES] = out_ready;

    // Input is refused during reset and flush so nothing sneaks past a discard.
    assign in_ready   = w_accept[0] & ~flush & ~rst;
    assign w_in_xfer  = in_valid & in_ready;

    assign out_valid  = w_valid[STAGES-1];
    assign out_data   = w_data[STAGES-1];
    assign w_out_xfer = out_valid & out_ready;
    assign count      = r_count;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (gi == 0) begin : g_head
            assign w_up_valid = w_in_xfer;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[gi-1];
            assign w_up_data  = w_data[gi-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .flush         (flush),
            .i_up_valid    (w_up_valid),
            .i_up_data     (w_up_data),
            .i_down_accept (w_accept[gi+1]),
            .o_accept      (w_accept[gi]),
            .o_valid       (w_valid[gi]),
            .o_data        (w_data[gi])
        );
    end

    // Occupancy tracks transfers in and out; a simultaneous pair cancels.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + CW'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule
`default_nettype wire
